// File: rtl/usb_param_reg_bank_if.sv
// FTDI receive-side bus of the parametrised register bank: byte stream in, live registers and pulses out.
// Read-back port group present only when USB_REG_BANK_RDBK_EN is defined.
interface usb_param_reg_bank_if #(
  parameter int unsigned N_REGS    = 4,
  parameter int unsigned REG_BYTES = 8
);
  localparam int unsigned REGS_W = N_REGS * REG_BYTES * 8;

  logic [7:0]        d;
  logic              d_accepted;
  logic [REGS_W-1:0] regs_q;
  logic [N_REGS-1:0] upd;
  logic              pkt_err;
  logic              busy;
`ifdef USB_REG_BANK_RDBK_EN
  logic [7:0]        rd_byte;
  logic              rd_valid;
  logic              rd_ready;

  modport master (output d, d_accepted, rd_ready,
                  input  regs_q, upd, pkt_err, busy, rd_byte, rd_valid);
  modport slave  (input  d, d_accepted, rd_ready,
                  output regs_q, upd, pkt_err, busy, rd_byte, rd_valid);
`else
  modport master (output d, d_accepted,
                  input  regs_q, upd, pkt_err, busy);
  modport slave  (input  d, d_accepted,
                  output regs_q, upd, pkt_err, busy);
`endif
endinterface

// File: rtl/usb_param_reg_bank.sv
// Parses CTRL/ADDR/DATA packets from the FTDI byte stream into N_REGS shadowed registers,
// committing only well-formed packets. Optional read-back streaming via USB_REG_BANK_RDBK_EN.
module usb_param_reg_bank #(
  parameter int unsigned N_REGS    = 4,
  parameter int unsigned REG_BYTES = 8,
  parameter logic [7:0]  ADDR_BASE = 8'h08
) (
  input logic                 clk_ftdi,
  input logic                 n_rst,
  usb_param_reg_bank_if.slave bus
);
  localparam int unsigned REG_W = REG_BYTES * 8;
  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned CNT_W = $clog2(REG_BYTES + 2);
  localparam logic [8:0]  ADDR_LO = 9'(ADDR_BASE);
  localparam logic [8:0]  ADDR_HI = 9'(ADDR_BASE) + 9'(N_REGS);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DROP, RDBK} state_t;

  state_t            state_q;
  logic [7:0]        addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [REG_W-1:0]  shadow_q;
  logic [REG_W-1:0]  regs_q [N_REGS];
  logic [N_REGS-1:0] upd_q;
  logic              pkt_err_q;
  logic [7:0]        addr_eff_c;
  logic [7:0]        addr_q_eff_c;
  logic [IDX_W-1:0]  idx_c;
`ifdef USB_REG_BANK_RDBK_EN
  logic [7:0]        rd_byte_q;
  logic              rd_valid_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic              rd_drop_q;

  // With read-back enabled bit7 flags a read, so the address proper is the low seven bits.
  assign addr_eff_c   = {1'b0, bus.d[6:0]};
  assign addr_q_eff_c = {1'b0, addr_q[6:0]};

  function automatic logic [7:0] reg_byte(input logic [REG_W-1:0] v, input logic [CNT_W-1:0] k);
    logic [7:0] r;
    r = '0;
    for (int unsigned b = 0; b < REG_BYTES; b++) begin
      if (k == CNT_W'(b)) r = v[REG_W-1-8*b -: 8];
    end
    return r;
  endfunction
`else
  assign addr_eff_c   = bus.d;
  assign addr_q_eff_c = addr_q;
`endif

  // Range check in 9 bits so ADDR_BASE+N_REGS past 255 cannot wrap.
  function automatic logic addr_ok(input logic [7:0] a);
    return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} < ADDR_HI);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [7:0] a);
    return IDX_W'(a - ADDR_BASE);
  endfunction

  assign idx_c = addr_idx(addr_q_eff_c);

  always_ff @(posedge clk_ftdi or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      upd_q     <= '0;
      pkt_err_q <= 1'b0;
      for (int unsigned i = 0; i < N_REGS; i++) regs_q[i] <= '0;
`ifdef USB_REG_BANK_RDBK_EN
      rd_byte_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_cnt_q   <= '0;
      rd_drop_q  <= 1'b0;
`endif
    end else begin
      upd_q     <= '0;
      pkt_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.d_accepted) state_q <= ADDR;
        end
        ADDR: begin
          addr_q <= bus.d;
          cnt_q  <= '0;
          if (!bus.d_accepted) begin
            state_q   <= IDLE;
            pkt_err_q <= 1'b1;
          end else if (addr_ok(addr_eff_c)) begin
            state_q  <= DATA;
            shadow_q <= regs_q[addr_idx(addr_eff_c)];
          end else begin
            state_q <= DROP;
          end
        end
        DATA: begin
          if (bus.d_accepted) begin
            for (int unsigned b = 0; b < REG_BYTES; b++) begin
              if (cnt_q == CNT_W'(b)) shadow_q[REG_W-1-8*b -: 8] <= bus.d;
            end
            if (cnt_q != CNT_W'(REG_BYTES + 1)) cnt_q <= cnt_q + CNT_W'(1);
`ifdef USB_REG_BANK_RDBK_EN
          end else if (addr_q[7]) begin
            state_q    <= RDBK;
            rd_valid_q <= 1'b1;
            rd_byte_q  <= reg_byte(regs_q[idx_c], '0);
            rd_cnt_q   <= '0;
            rd_drop_q  <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
            if (cnt_q == CNT_W'(REG_BYTES)) begin
              regs_q[idx_c] <= shadow_q;
              upd_q[idx_c]  <= 1'b1;
            end else begin
              pkt_err_q <= 1'b1;
            end
          end
        end
        DROP: begin
          if (!bus.d_accepted) begin
            state_q   <= IDLE;
            pkt_err_q <= 1'b1;
          end
        end
`ifdef USB_REG_BANK_RDBK_EN
        RDBK: begin
          // A packet arriving mid-stream is discarded and flagged once it ends.
          if (bus.d_accepted) begin
            rd_drop_q <= 1'b1;
          end else if (rd_drop_q) begin
            rd_drop_q <= 1'b0;
            pkt_err_q <= 1'b1;
          end
          if (rd_valid_q && bus.rd_ready) begin
            if (rd_cnt_q == CNT_W'(REG_BYTES - 1)) begin
              rd_valid_q <= 1'b0;
              if (bus.d_accepted) begin
                state_q   <= DROP;
                rd_drop_q <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
              rd_byte_q <= reg_byte(regs_q[idx_c], rd_cnt_q + CNT_W'(1));
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_flat
    assign bus.regs_q[i*REG_W +: REG_W] = regs_q[i];
  end

  assign bus.upd     = upd_q;
  assign bus.pkt_err = pkt_err_q;
  assign bus.busy    = (state_q != IDLE);
`ifdef USB_REG_BANK_RDBK_EN
  assign bus.rd_byte  = rd_byte_q;
  assign bus.rd_valid = rd_valid_q;
`endif
endmodule
